dmem_responder: RTL

//  Data-memory responder for the CPU's load/store path: accepts one word request through a

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the CPU load/store path.
// A request is accepted through a valid/ready handshake, held for a fixed LATENCY, then
// completed with a one-cycle registered response (read data and error flag).
// Optional feature macro: DMEM_BYTE_WRITE_EN adds the req_be port and byte-masked stores.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic        w_enter_resp;
  logic        w_accept;

  // Request fields captured at the accept edge
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  r_be;
`endif

  // Operation being completed: with LATENCY==1 the response is formed on the accept edge
  // itself, so the live request fields are used while still in IDLE.
  logic             w_op_we;
  logic [31:0]      w_op_addr;
  logic [31:0]      w_op_wdata;
  logic [3:0]       w_op_be;
  logic             w_op_err;
  logic [IDX_W-1:0] w_op_idx;
  logic             w_mem_we;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  assign req_ready = (r_state == S_IDLE) && reset;
  assign w_accept  = req_valid && req_ready;

  assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  assign w_op_be    = (r_state == S_IDLE) ? req_be    : r_be;
`else
  assign w_op_be    = 4'hF;
`endif

  assign w_op_err = (w_op_addr[1:0] != 2'b00) ||
                    ({2'b00, w_op_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_op_idx = w_op_addr[IDX_W+1:2];
  // A reset edge aborts the pending operation, so a store never lands during reset.
  assign w_mem_we = w_enter_resp && w_op_we && !w_op_err && reset;

  // Next-state and latency counter decode
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next_state = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and latency counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Capture request fields on the accept edge only
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
      r_be    <= 4'd0;
`endif
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
      r_be    <= req_be;
`endif
    end
  end

  // Storage array write on the edge entering RESP
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive reset and it maps to plain RAM.
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_op_be[b]) begin
          r_mem[w_op_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered response, valid for the single RESP cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      r_resp_err   <= w_enter_resp && w_op_err;
      if (w_enter_resp && !w_op_we && !w_op_err) begin
        r_resp_rdata <= r_mem[w_op_idx];
      end else begin
        r_resp_rdata <= 32'd0;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule
